// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, input-valid gating,
// overlap/non-overlap modes, pulse or sticky match, and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned            PAT_W       = 4,
    parameter int unsigned            CNT_W       = 8,
    parameter logic [PAT_W-1:0]       PAT_DEFAULT = 4'b1010
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic                         cfg_overlap,
    input  logic                         cfg_sticky,
    input  logic                         clear,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);

    localparam int unsigned           FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              sticky;
    logic [PAT_W-1:0]  history;

    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    always_comb begin
        shifted  = {history[PAT_W-2:0], in};
        fill_inc = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
        // Zero-padded history must never hit before PAT_W real bits arrive.
        hit      = in_valid && (fill_inc == FILL_MAX) && (shifted == pattern);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern   <= PAT_DEFAULT;
            overlap   <= 1'b0;
            sticky    <= 1'b0;
            history   <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (cfg_load) begin
            pattern   <= cfg_pattern;
            overlap   <= cfg_overlap;
            sticky    <= cfg_sticky;
            history   <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (clear) begin
            history   <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (in_valid) begin
                if (hit && !overlap) begin
                    history <= '0;
                    fill    <= '0;
                end else begin
                    history <= shifted;
                    fill    <= fill_inc;
                end
            end
            match <= sticky ? (match | hit) : hit;
            if (hit && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule
